// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM states, funct3 encodings and default width for the MEM-stage LSU.
package mem_pkg;
  localparam int XLEN_DEF = 64;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane alignment of store data/strobes, legality check and load extraction.
module lsu_align import mem_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]                   funct3,
  input  logic [$clog2(XLEN/8)-1:0]    off,
  input  logic                         is_store,
  input  logic [XLEN-1:0]              wdata_in,
  input  logic [XLEN-1:0]              rdata,
  output logic [XLEN/8-1:0]            wstrb,
  output logic [XLEN-1:0]              wdata,
  output logic [XLEN-1:0]              rdata_ext,
  output logic                         legal
);
  localparam int OW = $clog2(XLEN/8);
  logic [3:0]      bytes;
  logic [XLEN-1:0] sh;
  assign bytes = 4'd1 << funct3[1:0];
  assign wstrb = is_store ? (XLEN/8)'((16'd1 << bytes) - 16'd1) << off : '0;
  assign wdata = is_store ? wdata_in << {off, 3'b000} : '0;
  assign legal = funct3 != 3'b111 && !(is_store && funct3[2]) && (off & OW'(bytes - 4'd1)) == '0;
  assign sh    = rdata >> {off, 3'b000};
  assign rdata_ext = funct3 == F3_B  ? {{(XLEN-8){sh[7]}}, sh[7:0]} :
                     funct3 == F3_H  ? {{(XLEN-16){sh[15]}}, sh[15:0]} :
                     funct3 == F3_W  ? {{(XLEN-32){sh[31]}}, sh[31:0]} :
                     funct3 == F3_BU ? {{(XLEN-8){1'b0}}, sh[7:0]} :
                     funct3 == F3_HU ? {{(XLEN-16){1'b0}}, sh[15:0]} :
                     funct3 == F3_WU ? {{(XLEN-32){1'b0}}, sh[31:0]} : sh;
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit; one bus access at a time, stalling upstream until it retires.
module mem_stage_lsu import mem_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [2:0]        funct3_in,
  input  logic [XLEN-1:0]   addr_in,
  input  logic [XLEN-1:0]   store_data_in,
  output logic              stall_out,
  output logic              load_valid_out,
  output logic [XLEN-1:0]   load_data_out,
  output logic              fault_out,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [XLEN-1:0]   bus_req_addr,
  output logic              bus_req_we,
  output logic [XLEN-1:0]   bus_req_wdata,
  output logic [XLEN/8-1:0] bus_req_wstrb,
  input  logic              bus_resp_valid,
  input  logic [XLEN-1:0]   bus_resp_rdata
);
  localparam int OW = $clog2(XLEN/8);
  lsu_state_e        state, state_d;
  logic              st_q, flt_q, access, idle, a_legal, legal_in;
  logic [2:0]        f3_q;
  logic [OW-1:0]     off_q;
  logic [XLEN/8-1:0] a_wstrb;
  logic [XLEN-1:0]   a_wdata, a_ext;
  assign access   = mem_read_in | mem_write_in;
  assign idle     = state == IDLE;
  assign legal_in = a_legal & ~(mem_read_in & mem_write_in);
  // In IDLE the aligner judges the incoming request; afterwards it works on the latched copy.
  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3   (idle ? funct3_in : f3_q),
    .off      (idle ? addr_in[OW-1:0] : off_q),
    .is_store (idle ? mem_write_in : st_q),
    .wdata_in (store_data_in),
    .rdata    (bus_resp_rdata),
    .wstrb    (a_wstrb),
    .wdata    (a_wdata),
    .rdata_ext(a_ext),
    .legal    (a_legal)
  );
  always_comb begin
    state_d = idle ? (access ? (legal_in ? REQ : DONE) : IDLE) :
              state == REQ ? (bus_req_ready ? RESP : REQ) :
              state == RESP ? (bus_resp_valid ? DONE : RESP) : IDLE;
    stall_out      = reset & (state == REQ | state == RESP | (idle & access));
    bus_req_valid  = state == REQ;
    load_valid_out = state == DONE & ~st_q & ~flt_q;
    fault_out      = state == DONE & flt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      st_q          <= 1'b0;
      flt_q         <= 1'b0;
      f3_q          <= '0;
      off_q         <= '0;
      bus_req_addr  <= '0;
      bus_req_we    <= 1'b0;
      bus_req_wdata <= '0;
      bus_req_wstrb <= '0;
      load_data_out <= '0;
    end else begin
      state <= state_d;
      if (idle && access) begin
        st_q          <= mem_write_in;
        flt_q         <= ~legal_in;
        f3_q          <= funct3_in;
        off_q         <= addr_in[OW-1:0];
        bus_req_addr  <= {addr_in[XLEN-1:OW], OW'(0)};
        bus_req_we    <= mem_write_in;
        bus_req_wdata <= a_wdata;
        bus_req_wstrb <= a_wstrb;
      end
      if (state == RESP && bus_resp_valid && !st_q) load_data_out <= a_ext;
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed accesses against a schedule/transaction model of the LSU.
module tb_mem_stage_lsu;
  logic        clk = 0, reset = 0;
  logic        mem_read_in = 0, mem_write_in = 0, bus_req_ready = 0, bus_resp_valid = 0;
  logic [2:0]  funct3_in = 0;
  logic [63:0] addr_in = 0, store_data_in = 0, bus_resp_rdata = 0;
  logic        stall_out, load_valid_out, fault_out, bus_req_valid, bus_req_we;
  logic [63:0] load_data_out, bus_req_addr, bus_req_wdata;
  logic [7:0]  bus_req_wstrb;
  int total = 0, bad = 0, stall_cnt = 0, fault_cnt = 0;
  logic        chk_en = 0, e_stall = 0, e_valid = 0, e_lv = 0, e_flt = 0, e_we = 0;
  logic [63:0] e_addr = 0, e_wdata = 0, e_ld = 0, cap_addr = 0, cap_wdata = 0;
  logic [7:0]  e_strb = 0, cap_strb = 0;
  logic        cap_we = 0;

  mem_stage_lsu #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .funct3_in(funct3_in), .addr_in(addr_in), .store_data_in(store_data_in),
    .stall_out(stall_out), .load_valid_out(load_valid_out), .load_data_out(load_data_out),
    .fault_out(fault_out), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_addr(bus_req_addr), .bus_req_we(bus_req_we), .bus_req_wdata(bus_req_wdata),
    .bus_req_wstrb(bus_req_wstrb), .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic logic legal_f(logic rd, logic wr, logic [2:0] f3, logic [63:0] a);
    int sz = 1 << f3[1:0];
    return !(rd && wr) && f3 != 3'd7 && !(wr && f3[2]) && (a % 64'(sz)) == 0;
  endfunction

  function automatic logic [7:0] strb_f(logic [2:0] f3, logic [63:0] a);
    int sz = 1 << f3[1:0];
    logic [15:0] m = (16'd1 << sz) - 16'd1;
    return 8'(m << (a % 8));
  endfunction

  function automatic logic [63:0] load_f(logic [2:0] f3, logic [63:0] a, logic [63:0] r);
    logic [63:0] v = r >> (8 * (a % 8));
    case (f3)
      3'd0: return (v[7]  ? ~64'hFF       : 64'h0) | (v & 64'hFF);
      3'd1: return (v[15] ? ~64'hFFFF     : 64'h0) | (v & 64'hFFFF);
      3'd2: return (v[31] ? ~64'hFFFFFFFF : 64'h0) | (v & 64'hFFFFFFFF);
      3'd4: return v & 64'hFF;
      3'd5: return v & 64'hFFFF;
      3'd6: return v & 64'hFFFFFFFF;
      default: return v;
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("stall", 64'(stall_out), 64'(e_stall));
      chk("req_valid", 64'(bus_req_valid), 64'(e_valid));
      chk("load_valid", 64'(load_valid_out), 64'(e_lv));
      chk("fault", 64'(fault_out), 64'(e_flt));
      chk("load_data", load_data_out, e_ld);
      if (e_valid) begin
        chk("req_addr", bus_req_addr, e_addr);
        chk("req_we", 64'(bus_req_we), 64'(e_we));
        chk("req_wstrb", 64'(bus_req_wstrb), 64'(e_strb));
        if (e_we) chk("req_wdata", bus_req_wdata, e_wdata);
        cap_addr = bus_req_addr; cap_we = bus_req_we; cap_strb = bus_req_wstrb; cap_wdata = bus_req_wdata;
      end
      if (stall_out) stall_cnt++;
      if (fault_out) fault_cnt++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] sd, input logic [63:0] rdata, input int rdly, input int pdly);
    logic ok = legal_f(rd, wr, f3, a);
    mem_read_in = rd; mem_write_in = wr; funct3_in = f3; addr_in = a; store_data_in = sd;
    e_stall = rd | wr; e_valid = 0; e_lv = 0; e_flt = 0;
    step();
    if (ok) begin
      addr_in = ~a; store_data_in = ~sd;
      e_valid = 1; e_addr = {a[63:3], 3'b000}; e_we = wr; e_strb = wr ? strb_f(f3, a) : 8'h00;
      e_wdata = sd << (8 * (a % 8));
      for (int i = 0; i <= rdly; i++) begin bus_req_ready = (i == rdly); step(); end
      bus_req_ready = 0; e_valid = 0;
      for (int i = 0; i <= pdly; i++) begin
        bus_resp_valid = (i == pdly);
        bus_resp_rdata = (i == pdly) ? rdata : 64'hDEADBEEF0BADF00D;
        step();
      end
      bus_resp_valid = 0;
    end
    mem_read_in = 0; mem_write_in = 0;
    e_stall = 0; e_lv = ok && rd && !wr; e_flt = !ok;
    if (ok && rd) e_ld = load_f(f3, a, rdata);
    step();
    e_lv = 0; e_flt = 0;
  endtask

  initial begin
    step(); step();
    chk("rst_stall", 64'(stall_out), 0);
    chk("rst_valid", 64'(bus_req_valid), 0);
    chk("rst_lv", 64'(load_valid_out), 0);
    chk("rst_fault", 64'(fault_out), 0);
    chk("rst_ld", load_data_out, 0);
    chk("rst_wstrb", 64'(bus_req_wstrb), 0);
    reset = 1; chk_en = 1;
    step();
    stall_cnt = 0;
    access(1, 0, 3'd3, 64'h1000, 0, 64'h1122334455667788, 0, 0);
    chk("ld_lit", load_data_out, 64'h1122334455667788);
    chk("ld_stall_cycles", 64'(stall_cnt), 3);
    access(1, 0, 3'd0, 64'h1003, 0, 64'h0000000080000000, 0, 0);
    chk("lb_lit", load_data_out, 64'hFFFFFFFFFFFFFF80);
    access(1, 0, 3'd4, 64'h1003, 0, 64'h0000000080000000, 0, 0);
    chk("lbu_lit", load_data_out, 64'h80);
    access(0, 1, 3'd1, 64'h1006, 64'hABCD, 0, 0, 0);
    chk("sh_strb_lit", 64'(cap_strb), 64'hC0);
    chk("sh_wdata_lit", 64'(cap_wdata[63:48]), 64'hABCD);
    chk("sh_addr_lit", cap_addr, 64'h1000);
    chk("sh_we_lit", 64'(cap_we), 1);
    fault_cnt = 0;
    access(1, 0, 3'd2, 64'h1002, 0, 0, 0, 0);
    chk("lw_mis_fault_cnt", 64'(fault_cnt), 1);
    chk("lw_mis_keeps_ld", load_data_out, 64'h80);
    stall_cnt = 0;
    access(1, 0, 3'd3, 64'h2008, 0, 64'hCAFEF00D12345678, 3, 5);
    chk("slow_ld_stall_cycles", 64'(stall_cnt), 11);
    access(1, 0, 3'd1, 64'h200E, 0, 64'h8001000000000000, 1, 0);
    access(1, 0, 3'd6, 64'h2004, 0, 64'hF00000000000000F, 0, 2);
    access(1, 0, 3'd5, 64'h2002, 0, 64'h00000000F0F00000, 0, 0);
    access(1, 0, 3'd2, 64'h2004, 0, 64'h8000000000000000, 0, 0);
    access(0, 1, 3'd0, 64'h3005, 64'h5A, 0, 2, 1);
    access(0, 1, 3'd2, 64'h3004, 64'h89ABCDEF, 0, 0, 0);
    access(0, 1, 3'd3, 64'h3000, 64'h0123456789ABCDEF, 0, 0, 0);
    access(0, 1, 3'd4, 64'h3000, 64'h1, 0, 0, 0);
    access(1, 0, 3'd7, 64'h3000, 0, 0, 0, 0);
    access(1, 1, 3'd3, 64'h3000, 0, 0, 0, 0);
    access(1, 0, 3'd3, 64'h1004, 0, 0, 0, 0);
    access(0, 1, 3'd1, 64'h1001, 64'h1, 0, 0, 0);
    bus_resp_valid = 1; bus_resp_rdata = 64'hFFFFFFFFFFFFFFFF;
    step();
    bus_resp_valid = 0;
    step();
    mem_read_in = 1; funct3_in = 3'd3; addr_in = 64'h4000;
    e_stall = 1; step();
    e_valid = 1; e_addr = 64'h4000; e_we = 0; e_strb = 0; bus_req_ready = 1; step();
    bus_req_ready = 0; e_valid = 0;
    chk_en = 0; reset = 0; #1;
    chk("mid_rst_stall", 64'(stall_out), 0);
    chk("mid_rst_valid", 64'(bus_req_valid), 0);
    chk("mid_rst_lv", 64'(load_valid_out), 0);
    chk("mid_rst_fault", 64'(fault_out), 0);
    chk("mid_rst_ld", load_data_out, 0);
    chk("mid_rst_addr", bus_req_addr, 0);
    mem_read_in = 0; funct3_in = 0; addr_in = 0;
    step();
    reset = 1; e_stall = 0; e_ld = 0; chk_en = 1;
    step();
    access(1, 0, 3'd2, 64'h5004, 0, 64'h7FFFFFFF00000000, 0, 0);
    chk("post_rst_lw_lit", load_data_out, 64'h7FFFFFFF);
    step();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
